// File: rtl/axi_r_resp_router_if.sv
// R-channel bundle for axi_r_resp_router: prefixed slave-side beat in, two stripped master-side beats out.
// The "slave" modport is the router's own view; "master" is the view of the surrounding fabric/bench.
interface axi_r_resp_router_if #(
    parameter int AXI_ID_BITS   = 4,
    parameter int AXI_DATA_BITS = 32,
    parameter int IDX_BITS      = 4
);
    logic [AXI_ID_BITS+IDX_BITS-1:0] RID_S;
    logic [AXI_DATA_BITS-1:0]        RDATA_S;
    logic [1:0]                      RRESP_S;
    logic                            RLAST_S;
    logic                            RVALID_S;
    logic                            RREADY_S;

    logic [AXI_ID_BITS-1:0]          RID_M0;
    logic [AXI_DATA_BITS-1:0]        RDATA_M0;
    logic [1:0]                      RRESP_M0;
    logic                            RLAST_M0;
    logic                            RVALID_M0;
    logic                            RREADY_M0;

    logic [AXI_ID_BITS-1:0]          RID_M1;
    logic [AXI_DATA_BITS-1:0]        RDATA_M1;
    logic [1:0]                      RRESP_M1;
    logic                            RLAST_M1;
    logic                            RVALID_M1;
    logic                            RREADY_M1;

    modport slave (
        input  RID_S, RDATA_S, RRESP_S, RLAST_S, RVALID_S,
        output RREADY_S,
        output RID_M0, RDATA_M0, RRESP_M0, RLAST_M0, RVALID_M0,
        input  RREADY_M0,
        output RID_M1, RDATA_M1, RRESP_M1, RLAST_M1, RVALID_M1,
        input  RREADY_M1
    );

    modport master (
        output RID_S, RDATA_S, RRESP_S, RLAST_S, RVALID_S,
        input  RREADY_S,
        input  RID_M0, RDATA_M0, RRESP_M0, RLAST_M0, RVALID_M0,
        output RREADY_M0,
        input  RID_M1, RDATA_M1, RRESP_M1, RLAST_M1, RVALID_M1,
        output RREADY_M1
    );
endinterface

// File: rtl/axi_r_resp_router.sv
// AXI read-data router: strips the master-index prefix from RID and steers beats to M0/M1 through a 2-entry skid FIFO.
// Optional macro AXI_R_ROUTER_DROPCNT_EN adds a saturating stray-beat counter (drop_cnt) with a clear input.
module axi_r_resp_router #(
    parameter int AXI_ID_BITS   = 4,
    parameter int AXI_DATA_BITS = 32,
    parameter int IDX_BITS      = 4,
    parameter int FIFO_DEPTH    = 2
) (
    input  logic                     ACLK,
    input  logic                     ARESETn,
    axi_r_resp_router_if.slave       io_bus,
    output logic                     burst_open_M0,
    output logic                     burst_open_M1,
    output logic                     stray_err
`ifdef AXI_R_ROUTER_DROPCNT_EN
    ,
    input  logic                     drop_cnt_clr,
    output logic [7:0]               drop_cnt
`endif
);

    localparam logic [1:0] FULL_CNT = 2'(FIFO_DEPTH);

    typedef struct packed {
        logic                     idx;
        logic [AXI_ID_BITS-1:0]   id;
        logic [AXI_DATA_BITS-1:0] data;
        logic [1:0]               resp;
        logic                     last;
    } entry_t;

    entry_t     r_mem [2];
    logic       r_head;
    logic       r_tail;
    logic [1:0] r_count;
    logic       r_rreadyS;
    logic       r_stray;
    logic       r_open0;
    logic       r_open1;

    logic [IDX_BITS-1:0] w_idx;
    logic                w_push;
    logic                w_store;
    logic                w_stray;
    logic                w_pop;
    logic                w_valid0;
    logic                w_valid1;
    logic [1:0]          w_countNext;
    entry_t              w_newEntry;
    entry_t              w_headEntry;
    entry_t              w_outEntry;

    assign w_idx      = io_bus.RID_S[AXI_ID_BITS+IDX_BITS-1:AXI_ID_BITS];
    assign w_push     = io_bus.RVALID_S && r_rreadyS;
    assign w_store    = w_push && (w_idx[IDX_BITS-1:1] == '0);
    assign w_stray    = w_push && (w_idx[IDX_BITS-1:1] != '0);
    assign w_newEntry = '{idx:  w_idx[0],
                          id:   io_bus.RID_S[AXI_ID_BITS-1:0],
                          data: io_bus.RDATA_S,
                          resp: io_bus.RRESP_S,
                          last: io_bus.RLAST_S};

    assign w_headEntry = r_mem[r_head];
    assign w_valid0    = (r_count != 2'd0) && !w_headEntry.idx;
    assign w_valid1    = (r_count != 2'd0) &&  w_headEntry.idx;
    assign w_pop       = (w_valid0 && io_bus.RREADY_M0) || (w_valid1 && io_bus.RREADY_M1);
    assign w_countNext = r_count + {1'b0, w_store} - {1'b0, w_pop};

    // With two slots, the slot behind the head holds the last popped beat, so an empty FIFO keeps showing it.
    assign w_outEntry  = (r_count == 2'd0) ? r_mem[~r_head] : w_headEntry;

    assign io_bus.RREADY_S  = r_rreadyS;
    assign io_bus.RVALID_M0 = w_valid0;
    assign io_bus.RVALID_M1 = w_valid1;
    assign io_bus.RID_M0    = w_outEntry.id;
    assign io_bus.RID_M1    = w_outEntry.id;
    assign io_bus.RDATA_M0  = w_outEntry.data;
    assign io_bus.RDATA_M1  = w_outEntry.data;
    assign io_bus.RRESP_M0  = w_outEntry.resp;
    assign io_bus.RRESP_M1  = w_outEntry.resp;
    assign io_bus.RLAST_M0  = w_outEntry.last;
    assign io_bus.RLAST_M1  = w_outEntry.last;

    assign burst_open_M0 = r_open0;
    assign burst_open_M1 = r_open1;
    assign stray_err     = r_stray;

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            for (int i = 0; i < 2; i++) begin
                r_mem[i] <= '0;
            end
            r_head    <= 1'b0;
            r_tail    <= 1'b0;
            r_count   <= 2'd0;
            r_rreadyS <= 1'b0;
            r_stray   <= 1'b0;
            r_open0   <= 1'b0;
            r_open1   <= 1'b0;
        end else begin
            if (w_store) begin
                r_mem[r_tail] <= w_newEntry;
                r_tail        <= ~r_tail;
            end
            if (w_pop) begin
                r_head <= ~r_head;
                if (w_headEntry.idx) begin
                    r_open1 <= !w_headEntry.last;
                end else begin
                    r_open0 <= !w_headEntry.last;
                end
            end
            r_count   <= w_countNext;
            // Ready looks ahead at next occupancy so the slave never sees a combinational path from RREADY_Mx.
            r_rreadyS <= (w_countNext != FULL_CNT);
            r_stray   <= w_stray;
        end
    end

`ifdef AXI_R_ROUTER_DROPCNT_EN
    logic [7:0] r_dropCnt;

    assign drop_cnt = r_dropCnt;

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_dropCnt <= 8'd0;
        end else if (drop_cnt_clr) begin
            r_dropCnt <= 8'd0;
        end else if (w_stray && (r_dropCnt != 8'hFF)) begin
            r_dropCnt <= r_dropCnt + 8'd1;
        end
    end
`endif

endmodule
